// File: rtl/cyx_imem_pkg.sv
// Shared types and helpers for the host-loadable nanoMIPS instruction memory.
// The FSM states, the nop encoding and the byte-to-word address helper live here.
package cyx_imem_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [29:0] word_idx(input logic [31:0] adr);
        return 30'(adr >> 2);
    endfunction

endpackage

// File: rtl/cyx_imem_array.sv
// Single-port DEPTH x 32 storage: synchronous write, registered read.
// A write takes the port for the cycle; the read register only updates on a pure read.
module cyx_imem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register is reset so the CPU never observes X out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cyx_prog_imem.sv
// Host-loadable instruction memory: clears itself after reset, serves 1-cycle
// registered fetches, and accepts a streamed program over a valid/ready port.
module cyx_prog_imem
    import cyx_imem_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] DEFAULT_WORD = NOP_WORD,
    parameter int          CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_adr,
    output logic [31:0]      fetch_data,
    output logic             fetch_valid,
    output logic             fetch_err,
    input  logic             ld_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic [CNT_W-1:0] ld_count,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    state_t           state;
    logic [AW-1:0]    clr_ptr;
    logic [AW-1:0]    ld_ptr;
    logic [CNT_W-1:0] ld_count_q;

    logic             vld_p1;
    logic             err_p1;
    logic             oor_p1;

    logic [29:0]      fetch_wi;
    logic [AW-1:0]    fetch_idx;
    logic             fetch_oor;
    logic             fetch_mis;
    logic             xfer;

    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    assign fetch_wi  = word_idx(fetch_adr);
    assign fetch_idx = fetch_wi[AW-1:0];
    assign fetch_oor = (fetch_wi >= 30'(DEPTH));
    assign fetch_mis = |fetch_adr[1:0];

    // A restart in the same cycle as a handshake wins; the word is dropped.
    assign xfer = (state == LOAD) && ld_valid && !ld_start;

    // Storage port owner follows the state: INIT and LOAD write, RUN reads.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = fetch_idx;
        mem_wdata = DEFAULT_WORD;
        case (state)
            INIT: begin
                mem_we   = 1'b1;
                mem_addr = clr_ptr;
            end
            LOAD: begin
                mem_we    = xfer;
                mem_addr  = ld_ptr;
                mem_wdata = ld_data;
            end
            RUN: begin
                mem_re = fetch_req && !fetch_oor;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    cyx_imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            clr_ptr    <= '0;
            ld_ptr     <= '0;
            ld_count_q <= '0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            oor_p1     <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_IDX) begin
                        clr_ptr <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Fetch stage p0 -> p1: result appears one edge after the request.
                    if (fetch_req) begin
                        vld_p1 <= 1'b1;
                        err_p1 <= fetch_mis | fetch_oor;
                        oor_p1 <= fetch_oor;
                    end
                    if (ld_start) begin
                        state      <= LOAD;
                        ld_ptr     <= '0;
                        ld_count_q <= '0;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        ld_ptr     <= '0;
                        ld_count_q <= '0;
                    end else if (ld_valid) begin
                        ld_ptr <= ld_ptr + 1'b1;
                        if (ld_count_q != CNT_MAX) begin
                            ld_count_q <= ld_count_q + 1'b1;
                        end
                        if (ld_last || (ld_ptr == LAST_IDX)) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // The read register only moves on in-range fetches, so this mux also holds
    // the last returned word while fetch_valid is low.
    assign fetch_data  = oor_p1 ? DEFAULT_WORD : mem_rdata;
    assign fetch_valid = vld_p1;
    assign fetch_err   = err_p1;
    assign ld_ready    = (state == LOAD);
    assign ld_count    = ld_count_q;
    assign busy        = (state != RUN);

endmodule

// File: tb/tb_cyx_prog_imem.sv
// Directed bench for cyx_prog_imem: fetch expectations go into a queue when the
// request is driven and are popped when fetch_valid appears.
module tb_cyx_prog_imem;

    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             fetch_req;
    logic [31:0]      fetch_adr;
    logic [31:0]      fetch_data;
    logic             fetch_valid;
    logic             fetch_err;
    logic             ld_start;
    logic             ld_valid;
    logic             ld_ready;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic [CNT_W-1:0] ld_count;
    logic             busy;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cyx_prog_imem #(
        .DEPTH        (DEPTH),
        .DEFAULT_WORD (32'h0000_0000),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_adr   (fetch_adr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .fetch_err   (fetch_err),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_count    (ld_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any fetch result present there.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (fetch_valid === 1'b1) begin
            chk("valid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fetch_data", fetch_data, e.data);
                chk("fetch_err", 32'(fetch_err), 32'(e.err));
            end
        end
    endtask

    task automatic expect_drained(input string tag);
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic fetch(input logic [31:0] adr, input logic [31:0] data, input logic err);
        fetch_req = 1'b1;
        fetch_adr = adr;
        sb.push_back('{data: data, err: err});
        step();
        fetch_req = 1'b0;
        step();
        expect_drained("fetch_pending");
    endtask

    initial begin
        reset     = 1'b0;
        fetch_req = 1'b0;
        fetch_adr = '0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;

        // Reset values
        #3 reset = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);

        // INIT lasts DEPTH cycles; fetches and load starts are ignored meanwhile
        reset     = 1'b0;
        fetch_req = 1'b1;
        fetch_adr = 32'h0;
        ld_start  = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            step();
        end
        chk("init_busy_63", 32'(busy), 32'd1);
        step();
        fetch_req = 1'b0;
        ld_start  = 1'b0;
        chk("init_busy_64", 32'(busy), 32'd0);
        chk("init_fetch_valid", 32'(fetch_valid), 32'd0);
        step();
        chk("init_no_load", 32'(busy), 32'd0);

        // Back-to-back fetches of cleared memory
        fetch_req = 1'b1;
        fetch_adr = 32'd0;   sb.push_back('{data: 32'h0, err: 1'b0}); step();
        fetch_adr = 32'd4;   sb.push_back('{data: 32'h0, err: 1'b0}); step();
        fetch_adr = 32'd252; sb.push_back('{data: 32'h0, err: 1'b0}); step();
        fetch_req = 1'b0;
        step();
        chk("burst_valid_drop", 32'(fetch_valid), 32'd0);
        expect_drained("burst_pending");

        // Three-word program load ending on ld_last
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("ld_ready_after_start", 32'(ld_ready), 32'd1);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_count_start", 32'(ld_count), 32'd0);
        ld_valid = 1'b1;
        ld_data = 32'h8c22_0000; step();
        ld_data = 32'h8c23_0004; step();
        ld_data = 32'h0800_0002; ld_last = 1'b1; step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld3_count", 32'(ld_count), 32'd3);
        chk("ld3_busy", 32'(busy), 32'd0);
        chk("ld3_ready", 32'(ld_ready), 32'd0);
        fetch(32'd0,  32'h8c22_0000, 1'b0);
        fetch(32'd4,  32'h8c23_0004, 1'b0);
        fetch(32'd8,  32'h0800_0002, 1'b0);
        fetch(32'd12, 32'h0000_0000, 1'b0);

        // Out-of-range and misaligned fetches
        fetch(32'd256, 32'h0000_0000, 1'b1);
        fetch(32'd5,   32'h8c23_0004, 1'b1);
        chk("data_hold", fetch_data, 32'h8c23_0004);
        fetch(32'hFFFF_FFF0, 32'h0000_0000, 1'b1);

        // Restart mid-load drops the same-cycle word, then a throttled full load
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 32'hB000_0000; step();
        ld_data = 32'hB000_0001; step();
        chk("ld_count_two", 32'(ld_count), 32'd2);
        ld_start = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        step();
        ld_start = 1'b0;
        chk("restart_count", 32'(ld_count), 32'd0);
        chk("restart_ready", 32'(ld_ready), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            ld_valid = 1'b0;
            step();
            chk("full_ready", 32'(ld_ready), 32'd1);
            ld_valid = 1'b1;
            ld_data  = 32'hA500_0000 + 32'(k);
            step();
        end
        ld_valid = 1'b0;
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_ready_low", 32'(ld_ready), 32'd0);
        chk("full_count", 32'(ld_count), 32'd64);
        fetch_req = 1'b1;
        fetch_adr = 32'd0;   sb.push_back('{data: 32'hA500_0000, err: 1'b0}); step();
        fetch_adr = 32'd100; sb.push_back('{data: 32'hA500_0019, err: 1'b0}); step();
        fetch_adr = 32'd252; sb.push_back('{data: 32'hA500_003F, err: 1'b0}); step();
        fetch_req = 1'b0;
        step();
        expect_drained("full_fetch_pending");
        chk("count_hold", 32'(ld_count), 32'd64);

        // Fetch and ld_start in the same RUN cycle
        fetch_req = 1'b1;
        fetch_adr = 32'd8;
        ld_start  = 1'b1;
        sb.push_back('{data: 32'hA500_0002, err: 1'b0});
        step();
        fetch_req = 1'b0;
        ld_start  = 1'b0;
        chk("same_cycle_ready", 32'(ld_ready), 32'd1);
        expect_drained("same_cycle_pending");

        // Reset after two of five load words forces a full re-clear
        ld_valid = 1'b1;
        ld_data = 32'hC000_0000; step();
        ld_data = 32'hC000_0001; step();
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        chk("abort_count", 32'(ld_count), 32'd0);
        step();
        reset     = 1'b0;
        fetch_req = 1'b1;
        fetch_adr = 32'd8;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("reinit_valid", 32'(fetch_valid), 32'd0);
            chk("reinit_busy", 32'(busy), (i < DEPTH - 1) ? 32'd1 : 32'd0);
        end
        fetch_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            fetch_req = 1'b1;
            fetch_adr = 32'(k) * 32'd4;
            sb.push_back('{data: 32'h0, err: 1'b0});
            step();
        end
        fetch_req = 1'b0;
        step();
        expect_drained("reclear_pending");

        // Reset landing between a fetch request and its result
        fetch_req = 1'b1;
        fetch_adr = 32'd4;
        @(posedge clk);
        #2;
        reset     = 1'b1;
        fetch_req = 1'b0;
        #1;
        chk("midfetch_valid", 32'(fetch_valid), 32'd0);
        chk("midfetch_data", fetch_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
